key_led_ctrl: RTL
=================

KEY_LED_CTRL -- requirements
Module: key_led_ctrl

Interface
REQ-001 SHALL have parameter KEY_NUM, default 4: number of key/LED channels, range 1..8.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 1_000_000: stable-sample cycles required to accept a key level (20 ms at 50 MHz).
REQ-003 SHALL have parameter BLINK_CNT, default 25_000_000: cycles per blink half-period.
REQ-004 SHALL have parameter LONG_CNT, default 50_000_000: hold cycles that make a press a long press.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port key, input, KEY_NUM bits: raw asynchronous keys, active-low (0 = pressed).
REQ-008 SHALL have port mode, input, 2 bits: 0 = direct, 1 = toggle, 2 = blink, 3 = all-off.
REQ-009 SHALL have port led, output, KEY_NUM bits: LED drive, active-high.
REQ-010 SHALL have port key_press, output, KEY_NUM bits: one-cycle pulse per accepted press.
REQ-011 SHALL have port key_long, output, KEY_NUM bits: one-cycle pulse per accepted long press.

Function
REQ-012 SHALL pass each key bit through a 2-flop synchroniser before any other use.
REQ-013 SHALL keep, per channel, a debounce counter that clears whenever the synchronised sample differs from the stable level, and otherwise increments.
REQ-014 SHALL load the sample into the stable level when the counter reaches DEBOUNCE_CNT-1 with the sample still different; the counter then clears.
REQ-015 SHALL size the counters as $clog2(PARAM) bits and SHALL never let them wrap past their terminal value.
REQ-016 SHALL pulse key_press[i] for exactly one cycle on the cycle after stable[i] goes from 1 to 0. Total latency from a clean key edge is DEBOUNCE_CNT+3 cycles.
REQ-017 SHALL emit no key_press for glitches shorter than DEBOUNCE_CNT cycles. A glitch of any length restarts the count.
REQ-018 SHALL keep a per-channel toggle state tog[i], inverted on every key_press[i] in every mode.
REQ-019 SHALL drive led[i] = ~stable[i] in mode 0.
REQ-020 SHALL drive led[i] = tog[i] in mode 1.
REQ-021 SHALL drive led[i] = tog[i] & blink in mode 2. blink is a shared phase bit that inverts each time a shared free-running counter reaches BLINK_CNT-1.
REQ-022 SHALL drive led = 0 in mode 3.
REQ-023 SHALL make led registered, updating one cycle after its source changes. A mode change takes effect on the next cycle and does not alter tog.
REQ-024 SHALL handle simultaneous presses on several channels independently, in the same cycle, with no priority.

Reset
REQ-025 SHALL, while sys_rst_n = 0, force led = 0, key_press = 0, key_long = 0, tog = 0, blink = 0, all counters = 0, and synchroniser and stable flops = 1 (released).
REQ-026 SHALL treat a reset in mid-debounce or mid-hold as discarding the pending event, with no pulse after release.
REQ-027 SHALL require sys_rst_n to be asserted asynchronously and released synchronously by the system; this block adds no reset synchroniser.

Configuration
REQ-028 SHALL, when macro KEY_LONG_PRESS_EN is defined, keep a per-channel hold counter. This counter runs while stable[i] = 0 and saturates.
REQ-029 SHALL, with KEY_LONG_PRESS_EN defined, pulse key_long[i] once when the hold counter reaches LONG_CNT-1 and force tog[i] = 0 on that cycle. Releasing the key clears the hold counter.
REQ-030 SHALL, with KEY_LONG_PRESS_EN undefined, keep no hold counter and tie key_long to 0. All other behaviour is identical.

Verification (KEY_NUM=4, DEBOUNCE_CNT=8, BLINK_CNT=16, LONG_CNT=40)
REQ-031 SHALL cover: key[0] low for 3 cycles, then high -> no key_press, led unchanged in modes 0 and 1.
REQ-032 SHALL cover: mode=1, key[1] held low 20 cycles -> key_press[1] one pulse 11 cycles after the edge, led[1] 0->1; second press -> led[1] back to 0.
REQ-033 SHALL cover: mode=0, key[2] low 30 cycles -> led[2]=1 from edge+11 until release+11.
REQ-034 SHALL cover: mode=2 with tog[3]=1 -> led[3] toggles every 16 cycles; mode=3 -> led=0 next cycle; back to mode 2 -> blinking resumes.
REQ-035 SHALL cover: sys_rst_n pulsed low at cycle 5 of a key[0] debounce -> all outputs 0, no key_press after release.
REQ-036 SHALL cover, with KEY_LONG_PRESS_EN defined: mode=1, key[0] held 60 cycles -> key_press[0] then key_long[0] at hold count 40, led[0]=0; without the macro, key_long stays 0 and led[0]=1.

Source files
------------

// File: rtl/key_led_ctrl.sv
// Debounced active-low keys driving LEDs in direct, toggle, blink or all-off mode.
// Define KEY_LONG_PRESS_EN to add per-channel long-press detection (key_long, tog clear).
module key_led_ctrl #(
   parameter int KEY_NUM      = 4,
   parameter int DEBOUNCE_CNT = 1_000_000,
   parameter int BLINK_CNT    = 25_000_000,
   parameter int LONG_CNT     = 50_000_000
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [KEY_NUM-1:0] key,
   input  logic [1:0]         mode,
   output logic [KEY_NUM-1:0] led,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_long
);

   localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CNT - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CNT - 1);

   typedef enum logic [1:0] {
      MODE_DIRECT = 2'd0,
      MODE_TOGGLE = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_OFF    = 2'd3
   } mode_e;

   generate
      if (KEY_NUM < 1 || KEY_NUM > 8 || DEBOUNCE_CNT < 1 || BLINK_CNT < 1 || LONG_CNT < 2) begin : g_bad_param
         $error("key_led_ctrl: parameter out of range");
      end
   endgenerate

   logic [KEY_NUM-1:0] sync1, sync2;
   logic [KEY_NUM-1:0] stable, stable_d;
   logic [DW-1:0]      deb_cnt [KEY_NUM];
   logic [KEY_NUM-1:0] fall;
   logic [KEY_NUM-1:0] long_hit;
   logic [KEY_NUM-1:0] tog;
   logic [BW-1:0]      blink_cnt;
   logic               blink;

   // Released keys read as 1, so synchroniser and stable flops reset high.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1    <= '1;
         sync2    <= '1;
         stable   <= '1;
         stable_d <= '1;
         // NOTE: the counter array is ordinary flops, so every element is reset explicitly.
         for (int i = 0; i < KEY_NUM; i++) deb_cnt[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments keep sync1->sync2 a true two-stage pipeline.
         sync1    <= key;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < KEY_NUM; i++) begin
            if (sync2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_MAX) begin
               stable[i]  <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign fall = stable_d & ~stable;

`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CNT);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CNT - 1);
   localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CNT - 2);

   logic [LW-1:0] hold_cnt [KEY_NUM];

   always_comb begin
      // NOTE: default first so no path leaves long_hit unassigned (no latch).
      long_hit = '0;
      for (int i = 0; i < KEY_NUM; i++)
         long_hit[i] = ~stable[i] && (hold_cnt[i] == LONG_PRE);
   end

   // Hold counter saturates at LONG_CNT-1, so the long pulse fires once per hold.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_long <= '0;
         for (int i = 0; i < KEY_NUM; i++) hold_cnt[i] <= '0;
      end else begin
         key_long <= long_hit;
         for (int i = 0; i < KEY_NUM; i++) begin
            if (stable[i])                   hold_cnt[i] <= '0;
            else if (hold_cnt[i] != LONG_MAX) hold_cnt[i] <= hold_cnt[i] + 1'b1;
         end
      end
   end
`else
   assign long_hit = '0;
   assign key_long = '0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_press <= '0;
         tog       <= '0;
         blink_cnt <= '0;
         blink     <= 1'b0;
         led       <= '0;
      end else begin
         key_press <= fall;
         tog       <= (tog ^ fall) & ~long_hit;
         if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink     <= ~blink;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         case (mode_e'(mode))
            MODE_DIRECT: led <= ~stable;
            MODE_TOGGLE: led <= tog;
            MODE_BLINK:  led <= tog & {KEY_NUM{blink}};
            default:     led <= '0;
         endcase
      end
   end

endmodule
